// File: rtl/image_stream_ctrl.sv
// Frame sequencer for the pixel-source datapath.
// On an accepted start it reads one stored image set out of the pixel memory,
// one address per cycle, and streams the pixels out over valid/ready with
// first/last markers. The memory has a fixed 1-cycle read latency. Returns land
// in a 2-entry fall-through FIFO, so a return can leave in the same cycle it
// arrives. Reads are throttled so that queued plus in-flight pixels never
// exceed two.
//
// Stream handshake: a beat transfers in any cycle where out_valid && out_ready.
// While out_valid is high and out_ready is low, out_data, out_first and
// out_last hold stable. out_valid never drops until the beat transfers, except
// on abort or reset.
module image_stream_ctrl #(
  parameter int PIXELS   = 784,
  parameter int ADDR_W   = 10,
  parameter int NUM_SETS = 2,
  parameter int SEL_W    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SEL_W-1:0]  set_sel,
  input  logic              abort,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [SEL_W-1:0]  mem_sel,
  input  logic [7:0]        mem_rd_data,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_first,
  output logic              out_last,
  output logic              busy,
  output logic              frame_done,
  output logic              sel_err,
  output logic [15:0]       frame_cnt,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(PIXELS - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] issue_cnt;
  logic [ADDR_W-1:0] beat_cnt;
  logic              inflight;
  logic [7:0]        fifo_mem [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        fifo_count;

  logic              sel_valid, start_ok, start_bad, abort_hit;
  logic              pop, push_st, pop_st;
  logic [2:0]        occ_after_pop;

  // Start qualification and abort gating (abort only matters outside IDLE).
  always_comb begin
    sel_valid = int'(set_sel) < NUM_SETS;
    start_ok  = (state == S_IDLE) && start && sel_valid;
    start_bad = (state == S_IDLE) && start && !sel_valid;
    abort_hit = abort && (state != S_IDLE);
  end

  // Output head: stored FIFO entry first, otherwise the return arriving this cycle.
  always_comb begin
    out_valid = (fifo_count != 2'd0) || inflight;
    out_data  = 8'd0;
    if (fifo_count != 2'd0) begin
      out_data = fifo_mem[rd_ptr];
    end else if (inflight) begin
      out_data = mem_rd_data;
    end
    pop           = out_valid && out_ready;
    push_st       = inflight && !((fifo_count == 2'd0) && pop);
    pop_st        = pop && (fifo_count != 2'd0);
    occ_after_pop = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
    out_first     = out_valid && (beat_cnt == '0);
    out_last      = out_valid && (beat_cnt == LAST_IDX);
  end

  // Next-state and read-issue decision; abort overrides everything.
  always_comb begin
    state_nxt = state;
    mem_rd_en = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_ok) state_nxt = S_STREAM;
      end
      S_STREAM: begin
        mem_rd_en = occ_after_pop < 3'd2;
        if (mem_rd_en && (issue_cnt == LAST_IDX)) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if ((fifo_count == 2'd0) && !inflight) state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (abort_hit) begin
      state_nxt = S_IDLE;
      mem_rd_en = 1'b0;
    end
  end

  assign busy       = (state != S_IDLE);
  assign frame_done = (state == S_DONE) && !abort;
  assign mem_addr   = issue_cnt;
  assign state_dbg  = state;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Issue counter and latched image set; the address holds at the last pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt <= '0;
      mem_sel   <= '0;
    end else if (start_ok) begin
      issue_cnt <= '0;
      mem_sel   <= set_sel;
    end else if (mem_rd_en && (issue_cnt != LAST_IDX)) begin
      issue_cnt <= issue_cnt + ADDR_W'(1);
    end
  end

  // A read issued this cycle returns next cycle; abort suppresses the issue.
  always_ff @(posedge clk) begin
    if (rst) inflight <= 1'b0;
    else     inflight <= mem_rd_en;
  end

  // FIFO pointers and occupancy; flushed on abort.
  always_ff @(posedge clk) begin
    if (rst || abort_hit) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      if (push_st) wr_ptr <= ~wr_ptr;
      if (pop_st)  rd_ptr <= ~rd_ptr;
      fifo_count <= fifo_count + {1'b0, push_st} - {1'b0, pop_st};
    end
  end

  // FIFO storage; entries are only read while counted, so no reset needed.
  always_ff @(posedge clk) begin
    if (push_st) fifo_mem[wr_ptr] <= mem_rd_data;
  end

  // Output beat counter driving the first/last markers.
  always_ff @(posedge clk) begin
    if (rst)           beat_cnt <= '0;
    else if (start_ok) beat_cnt <= '0;
    else if (pop)      beat_cnt <= beat_cnt + ADDR_W'(1);
  end

  // Completed-frame counter (wraps naturally) and rejected-start pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= 16'd0;
      sel_err   <= 1'b0;
    end else begin
      if (frame_done) frame_cnt <= frame_cnt + 16'd1;
      sel_err <= start_bad;
    end
  end

endmodule
